// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: step/dir pulses are queued in a signed pending
// counter and replayed as A/B Gray edges no closer than MIN_DWELL clocks apart.
`timescale 1ns/1ps
module quad_encoder_gen #(
    parameter int MIN_DWELL = 4,
    parameter int PEND_W    = 8,
    parameter int POS_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    step,
    input  logic                    dir,
    input  logic                    clear_ovf,
    output logic                    phaseA,
    output logic                    phaseB,
    output logic                    busy,
    output logic                    overflow,
    output logic signed [POS_W-1:0] position
);

    localparam int DW_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    localparam logic signed [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
    localparam logic signed [PEND_W-1:0] PEND_MIN = {1'b1, {(PEND_W-1){1'b0}}};
    localparam logic signed [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic signed [PEND_W-1:0] PEND_NEG = {PEND_W{1'b1}};
    localparam logic [DW_W-1:0] DWELL_RELOAD = DW_W'(MIN_DWELL - 1);

    logic                     step_d_reg;
    logic signed [PEND_W-1:0] pending_reg,  pending_next;
    logic [DW_W-1:0]          dwell_reg,    dwell_next;
    logic                     phase_a_reg,  phase_a_next;
    logic                     phase_b_reg,  phase_b_next;
    logic                     overflow_reg, overflow_next;
    logic signed [POS_W-1:0]  position_reg, position_next;

    logic                     step_rise;
    logic                     saturated;
    logic                     emit;
    logic                     emit_fwd;
    logic signed [PEND_W-1:0] pend_in;
    logic signed [PEND_W-1:0] pend_out;

    always_comb begin
        step_rise = step && !step_d_reg;
        saturated = dir ? (pending_reg == PEND_MAX) : (pending_reg == PEND_MIN);
        emit      = (dwell_reg == '0) && enable && (pending_reg != '0);
        emit_fwd  = !pending_reg[PEND_W-1];

        pend_in = '0;
        if (step_rise && !saturated) begin
            pend_in = dir ? PEND_ONE : PEND_NEG;
        end

        pend_out = '0;
        if (emit) begin
            pend_out = emit_fwd ? PEND_ONE : PEND_NEG;
        end

        // Arrival and departure combine; saturation guards the arrival side,
        // and departure always moves toward zero, so no wrap is possible.
        pending_next = pending_reg + pend_in - pend_out;

        dwell_next    = dwell_reg;
        phase_a_next  = phase_a_reg;
        phase_b_next  = phase_b_reg;
        position_next = position_reg;
        if (emit) begin
            dwell_next = DWELL_RELOAD;
            if (emit_fwd) begin
                // 00 -> 10 -> 11 -> 01 -> 00
                phase_a_next  = !phase_b_reg;
                phase_b_next  = phase_a_reg;
                position_next = position_reg + POS_W'(1);
            end else begin
                phase_a_next  = phase_b_reg;
                phase_b_next  = !phase_a_reg;
                position_next = position_reg - POS_W'(1);
            end
        end else if (dwell_reg != '0) begin
            dwell_next = dwell_reg - DW_W'(1);
        end

        overflow_next = overflow_reg;
        if (step_rise && saturated) begin
            overflow_next = 1'b1;
        end else if (clear_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_d_reg   <= 1'b0;
            pending_reg  <= '0;
            dwell_reg    <= '0;
            phase_a_reg  <= 1'b0;
            phase_b_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            position_reg <= '0;
        end else begin
            step_d_reg   <= step;
            pending_reg  <= pending_next;
            dwell_reg    <= dwell_next;
            phase_a_reg  <= phase_a_next;
            phase_b_reg  <= phase_b_next;
            overflow_reg <= overflow_next;
            position_reg <= position_next;
        end
    end

    assign phaseA   = phase_a_reg;
    assign phaseB   = phase_b_reg;
    assign overflow = overflow_reg;
    assign position = position_reg;
    assign busy     = (pending_reg != '0) || (dwell_reg != '0);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: directed scenarios plus random step/dir traffic,
// each cycle compared against an integer-level model of the emitter.
`timescale 1ns/1ps
module tb_quad_encoder_gen;

    localparam int MIN_DWELL = 4;
    localparam int PEND_W    = 4;
    localparam int POS_W     = 6;
    localparam int PMAX      = (1 << (PEND_W - 1)) - 1;
    localparam int PMIN      = -(1 << (PEND_W - 1));
    localparam int POS_MASK  = (1 << POS_W) - 1;

    logic clk = 1'b0;
    logic rst_n, enable, step, dir, clear_ovf;
    logic phaseA, phaseB, busy, overflow;
    logic signed [POS_W-1:0] position;

    always #5 clk = ~clk;

    quad_encoder_gen #(.MIN_DWELL(MIN_DWELL), .PEND_W(PEND_W), .POS_W(POS_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .step(step), .dir(dir),
        .clear_ovf(clear_ovf), .phaseA(phaseA), .phaseB(phaseB), .busy(busy),
        .overflow(overflow), .position(position)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference state: queued steps, dwell countdown, Gray index 0..3, position
    int m_pend, m_dwell, m_g, m_pos;
    bit m_ovf, m_stepd;
    int ab_tab [4] = '{0, 2, 3, 1};   // {A,B} as 2-bit number per Gray index
    int prev_idx  = 0;
    int dec_count = 0;
    int cyc       = 0;
    int edge_q [$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int idx_of(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int pos_now();
        return int'(unsigned'(position));
    endfunction

    task automatic model_reset();
        m_pend = 0; m_dwell = 0; m_g = 0; m_pos = 0; m_ovf = 0; m_stepd = 0;
        prev_idx = 0;
    endtask

    task automatic model_step();
        bit det, emit, ovf_new;
        int out, inc;
        det  = step && !m_stepd;
        emit = (m_dwell == 0) && enable && (m_pend != 0);
        out  = emit ? ((m_pend > 0) ? 1 : -1) : 0;
        inc = 0; ovf_new = 0;
        if (det) begin
            if (dir && m_pend == PMAX)       ovf_new = 1;
            else if (!dir && m_pend == PMIN) ovf_new = 1;
            else                             inc = dir ? 1 : -1;
        end
        if (emit) begin
            m_g     = (m_g + out + 4) % 4;
            m_pos   = m_pos + out;
            m_dwell = MIN_DWELL - 1;
        end else if (m_dwell > 0) begin
            m_dwell--;
        end
        m_pend  = m_pend + inc - out;
        m_ovf   = ovf_new ? 1'b1 : (clear_ovf ? 1'b0 : m_ovf);
        m_stepd = step;
    endtask

    task automatic compare_all();
        int cur, d;
        check("phaseA",   int'(phaseA),   (ab_tab[m_g] >> 1) & 1);
        check("phaseB",   int'(phaseB),   ab_tab[m_g] & 1);
        check("busy",     int'(busy),     int'(m_pend != 0 || m_dwell != 0));
        check("overflow", int'(overflow), int'(m_ovf));
        check("position", pos_now(),      m_pos & POS_MASK);
        cur = idx_of(phaseA, phaseB);
        d   = (cur - prev_idx + 4) % 4;
        check("gray_legal", int'(d == 2), 0);
        if (d == 1) dec_count++;
        if (d == 3) dec_count--;
        if (d != 0) edge_q.push_back(cyc);
        prev_idx = cur;
    endtask

    task automatic tick(input logic s, input logic d);
        @(negedge clk);
        step = s;
        dir  = d;
        @(posedge clk);
        cyc++;
        model_step();
        #1 compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_A"},   int'(phaseA),   0);
        check({tag, "_B"},   int'(phaseB),   0);
        check({tag, "_busy"}, int'(busy),    0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_pos"}, pos_now(),      0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        step  = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int exp_ab [4] = '{2, 3, 1, 0};
        rst_n = 1'b0; enable = 1'b1; step = 1'b0; dir = 1'b1; clear_ovf = 1'b0;
        model_reset();

        // reset held while step/dir toggle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            step = 1'($urandom);
            dir  = 1'($urandom);
            @(posedge clk);
            #1 check_zero("rst_hold");
        end
        @(negedge clk);
        step  = 1'b0;
        rst_n = 1'b1;

        // four forward steps far apart: one edge per step, one clock after detect
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            check("t2_hold", int'({phaseA, phaseB}), i == 0 ? 0 : exp_ab[i-1]);
            tick(1'b0, 1'b1);
            check("t2_edge", int'({phaseA, phaseB}), exp_ab[i]);
            for (int j = 0; j < 18; j++) tick(1'b0, 1'b1);
        end
        check("t2_pos", pos_now(), 4);

        // fast burst: edges paced by the dwell
        p0 = pos_now();
        edge_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
        end
        for (int j = 0; j < 30; j++) tick(1'b0, 1'b1);
        check("t3_edges", edge_q.size(), 6);
        for (int i = 1; i < edge_q.size(); i++)
            check("t3_spacing", edge_q[i] - edge_q[i-1], MIN_DWELL);
        check("t3_pos", (pos_now() - p0) & POS_MASK, 6);

        // reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
        end
        check("burst_busy", int'(busy), 1);
        async_reset();

        // forward then reverse cancels back to the origin
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, i < 3);
            tick(1'b0, i < 3);
        end
        for (int j = 0; j < 20; j++) tick(1'b0, 1'b0);
        check("t4_pos", pos_now(), 0);
        check("t4_ab",  int'({phaseA, phaseB}), 0);

        // saturation with emitter disabled, then drain
        enable = 1'b0;
        p0 = pos_now();
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
        end
        check("t5_ovf", int'(overflow), 1);
        check("t5_hold_pos", pos_now(), p0);
        enable = 1'b1;
        for (int j = 0; j < 40; j++) tick(1'b0, 1'b1);
        check("t5_drain", (pos_now() - p0) & POS_MASK, PMAX);
        clear_ovf = 1'b1;
        tick(1'b0, 1'b1);
        clear_ovf = 1'b0;
        check("t5_clear", int'(overflow), 0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if (i % 50 == 0) enable = ($urandom_range(0, 3) != 0);
            clear_ovf = ($urandom_range(0, 30) == 0);
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
        end
        clear_ovf = 1'b0;
        enable    = 1'b1;
        for (int j = 0; j < 80; j++) tick(1'b0, 1'b1);
        check("rand_idle", int'(busy), 0);

        // loopback: 300 forward steps decoded from the A/B stream
        dec_count = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1);
            for (int j = 0; j < 4; j++) tick(1'b0, 1'b1);
        end
        for (int j = 0; j < 20; j++) tick(1'b0, 1'b1);
        check("loopback_count", dec_count, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
